// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
//
// Multiplies use 32 shift-add steps and divides use 32 restoring-subtract
// steps, both on operand magnitudes. The sign is corrected when the unit
// enters DONE. Divide-by-zero and signed overflow skip iteration and go
// straight to DONE.
//
// Optional feature macro: MULDIV_FAST_MUL_EN. When it is defined, every
// multiply uses a single-cycle 33x33 signed multiplier and goes straight
// to DONE.
//
// Ports:
//   clk             pipeline clock
//   rst_n           synchronous active-low reset
//   start_i         valid RV32M op in EX (held while stall_o=1)
//   funct3_i        RV32M operation select
//   operand_a_i     forwarded rs1 value
//   operand_b_i     forwarded rs2 value
//   flush_i         kill the EX instruction
//   stall_o         freeze the front of the pipeline
//   result_valid_o  one-cycle pulse while result_o is final
//   result_o        RV32M result (held between operations)
//   busy_o          unit is not IDLE
module ex_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] operand_a_i,
    input  logic [31:0] operand_b_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        result_valid_o,
    output logic [31:0] result_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_r, next_state_s;
    logic [2:0]  op_r;
    logic [63:0] acc_r;      // mul: {hi, lo} product; div: {remainder, quotient}
    logic [31:0] b_mag_r;
    logic        neg_r;
    logic [5:0]  cnt_r;
    logic [31:0] result_r;
    logic        valid_r;

    logic        is_mul_s, a_signed_s, b_signed_s, sa_s, sb_s, neg_in_s;
    logic [31:0] a_mag_s, b_mag_s;
    logic        div_zero_s, ovf_s, special_s;
    logic [31:0] special_res_s, busy_res_s, result_next_s;
    logic [63:0] step_acc_s, mul_step_s, div_step_s, prod_c_s;
    logic [32:0] add_s, shifted_s, diff_s;
    logic [31:0] div_val_s;

    // Decode the incoming op: signedness, magnitudes, result sign, special cases.
    always_comb begin
        is_mul_s   = ~funct3_i[2];
        a_signed_s = (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                     (funct3_i == 3'b100) || (funct3_i == 3'b110);
        b_signed_s = (funct3_i == 3'b001) || (funct3_i == 3'b100) ||
                     (funct3_i == 3'b110);
        sa_s       = a_signed_s & operand_a_i[31];
        sb_s       = b_signed_s & operand_b_i[31];
        a_mag_s    = sa_s ? (32'd0 - operand_a_i) : operand_a_i;
        b_mag_s    = sb_s ? (32'd0 - operand_b_i) : operand_b_i;
        // The remainder takes the dividend's sign. Products and quotients take sa^sb.
        if (!is_mul_s && funct3_i[1]) begin
            neg_in_s = sa_s;
        end else begin
            neg_in_s = sa_s ^ sb_s;
        end
        div_zero_s = ~is_mul_s & (operand_b_i == 32'd0);
        ovf_s      = ~is_mul_s & ~funct3_i[0] &
                     (operand_a_i == 32'h8000_0000) & (operand_b_i == 32'hFFFF_FFFF);
`ifdef MULDIV_FAST_MUL_EN
        special_s  = div_zero_s | ovf_s | is_mul_s;
`else
        special_s  = div_zero_s | ovf_s;
`endif
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [32:0] fast_a_s, fast_b_s;
    logic signed [65:0] fast_prod_s;

    // Single-cycle 33x33 signed multiply. The extension bit follows each operand's signedness.
    always_comb begin
        fast_a_s    = signed'({a_signed_s & operand_a_i[31], operand_a_i});
        fast_b_s    = signed'({b_signed_s & operand_b_i[31], operand_b_i});
        fast_prod_s = fast_a_s * fast_b_s;
    end
`endif

    // Result preloaded when the unit goes from IDLE straight to DONE.
    always_comb begin
        special_res_s = 32'd0;
        if (div_zero_s) begin
            special_res_s = funct3_i[1] ? operand_a_i : 32'hFFFF_FFFF;
        end else if (ovf_s) begin
            special_res_s = funct3_i[1] ? 32'd0 : 32'h8000_0000;
        end else begin
`ifdef MULDIV_FAST_MUL_EN
            special_res_s = (funct3_i[1:0] == 2'b00) ? fast_prod_s[31:0] : fast_prod_s[63:32];
`else
            special_res_s = 32'd0;
`endif
        end
    end

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        add_s      = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, b_mag_r} : 33'd0);
        mul_step_s = {add_s, acc_r[31:1]};
        shifted_s  = {acc_r[63:32], acc_r[31]};
        diff_s     = shifted_s - {1'b0, b_mag_r};
        if (!diff_s[32]) begin
            div_step_s = {diff_s[31:0], acc_r[30:0], 1'b1};
        end else begin
            div_step_s = {shifted_s[31:0], acc_r[30:0], 1'b0};
        end
        step_acc_s = op_r[2] ? div_step_s : mul_step_s;
    end

    // Sign-corrected final result after the last iteration step.
    always_comb begin
        prod_c_s  = neg_r ? (64'd0 - step_acc_s) : step_acc_s;
        div_val_s = op_r[1] ? step_acc_s[63:32] : step_acc_s[31:0];
        if (!op_r[2]) begin
            busy_res_s = (op_r[1:0] == 2'b00) ? prod_c_s[31:0] : prod_c_s[63:32];
        end else begin
            busy_res_s = neg_r ? (32'd0 - div_val_s) : div_val_s;
        end
        result_next_s = (state_r == ST_IDLE) ? special_res_s : busy_res_s;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic. A flush always returns the unit to IDLE.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i && !flush_i) begin
                    next_state_s = special_s ? ST_DONE : ST_BUSY;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (flush_i) begin
                    next_state_s = ST_IDLE;
                end else if (cnt_r == 6'd31) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_BUSY;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        stall_o = 1'b0;
        case (state_r)
            ST_IDLE: stall_o = start_i & ~flush_i;
            ST_BUSY: stall_o = ~flush_i;
            ST_DONE: stall_o = 1'b0;
            default: stall_o = 1'b0;
        endcase
        busy_o = (state_r != ST_IDLE);
    end

    // Datapath: operand latch, iteration, and result and valid registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_r     <= 3'd0;
            acc_r    <= 64'd0;
            b_mag_r  <= 32'd0;
            neg_r    <= 1'b0;
            cnt_r    <= 6'd0;
            result_r <= 32'd0;
            valid_r  <= 1'b0;
        end else begin
            valid_r <= (next_state_s == ST_DONE);
            // result_r changes only on entry to DONE.
            if ((next_state_s == ST_DONE) && (state_r != ST_DONE)) begin
                result_r <= result_next_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start_i && !flush_i) begin
                        op_r    <= funct3_i;
                        acc_r   <= {32'd0, a_mag_s};
                        b_mag_r <= b_mag_s;
                        neg_r   <= neg_in_s;
                        cnt_r   <= 6'd0;
                    end
                end
                ST_BUSY: begin
                    if (!flush_i) begin
                        acc_r <= step_acc_s;
                        cnt_r <= cnt_r + 6'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result_o       = result_r;
    assign result_valid_o = valid_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed testbench for ex_muldiv_unit: a table of RV32M vectors plus
// hand-written flush, reset and back-to-back sequences.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n, start, flush;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b;
    logic        stall, valid, busy;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MS = 1;
`else
    localparam int MS = 33;
`endif

    ex_muldiv_unit dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .funct3_i(funct3),
        .operand_a_i(op_a), .operand_b_i(op_b), .flush_i(flush),
        .stall_o(stall), .result_valid_o(valid), .result_o(result), .busy_o(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          stall_cycles;
        string       name;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Issue one op and hold start until DONE. Check the result, the stall length and the pulse count.
    task automatic run_op(input vec_t v);
        int stalls = 0;
        int pulses = 0;
        int cyc = 0;
        bit done = 1'b0;
        logic [31:0] got = 32'd0;
        @(negedge clk);
        start = 1'b1; funct3 = v.f; op_a = v.a; op_b = v.b;
        while (!done && cyc < 200) begin
            #1;
            if (stall) stalls++;
            if (valid) begin
                pulses++;
                got = result;
                done = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        #1;
        if (valid) pulses++;
        chk({v.name, " done"}, {31'd0, done}, 32'd1);
        chk({v.name, " result"}, got, v.exp);
        chk({v.name, " stall"}, stalls, v.stall_cycles);
        chk({v.name, " pulses"}, pulses, 32'd1);
        chk({v.name, " held"}, result, v.exp);
    endtask

    initial begin
        logic [31:0] last;
        int pulses;
        logic [31:0] got[2];
        bit switched;

        vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MS, "MUL"};
        vecs[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, MS, "MULH"};
        vecs[2]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, MS, "MULHSU"};
        vecs[3]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, MS, "MULHU"};
        vecs[4]  = '{3'b100, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA, 33, "DIV"};
        vecs[5]  = '{3'b110, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE, 33, "REM"};
        vecs[6]  = '{3'b101, 32'd20,         32'd3,         32'd6,         33, "DIVU"};
        vecs[7]  = '{3'b111, 32'd20,         32'd3,         32'd2,         33, "REMU"};
        vecs[8]  = '{3'b101, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  "DIVU0"};
        vecs[9]  = '{3'b111, 32'd5,          32'd0,         32'd5,         1,  "REMU0"};
        vecs[10] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  "DIVOVF"};
        vecs[11] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  "REMOVF"};
        vecs[12] = '{3'b100, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 1,  "DIV0"};
        vecs[13] = '{3'b110, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 1,  "REM0"};

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = 3'd0; op_a = 32'd0; op_b = 32'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst result", result, 32'd0);
        chk("rst valid", {31'd0, valid}, 32'd0);
        chk("rst stall", {31'd0, stall}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 14; i++) run_op(vecs[i]);
        last = vecs[13].exp;

        // Flush a DIV at BUSY cycle 10.
        @(negedge clk);
        start = 1'b1; funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd7;
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        #1;
        chk("flush busy", {31'd0, busy}, 32'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (valid) pulses++;
            @(negedge clk);
            #1;
        end
        chk("flush pulses", pulses, 32'd0);
        chk("flush result", result, last);

        // Reset a DIV at BUSY cycle 10.
        @(negedge clk);
        start = 1'b1; funct3 = 3'b100; op_a = 32'd1000; op_b = 32'd7;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        #1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset stall", {31'd0, stall}, 32'd0);
        chk("reset result", result, 32'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (valid) pulses++;
            @(negedge clk);
            #1;
        end
        chk("reset pulses", pulses, 32'd0);

        // Two back-to-back DIVU ops with start held through DONE.
        @(negedge clk);
        start = 1'b1; funct3 = 3'b101; op_a = 32'd100; op_b = 32'd7;
        pulses = 0; switched = 1'b0; got[0] = 32'd0; got[1] = 32'd0;
        for (int c = 0; c < 120 && pulses < 2; c++) begin
            #1;
            if (valid) begin
                got[pulses] = result;
                pulses++;
            end
            @(negedge clk);
            if (pulses == 1 && !switched) begin
                op_a = 32'd9; op_b = 32'd2;
                switched = 1'b1;
            end
        end
        start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (valid) pulses++;
            @(negedge clk);
        end
        chk("b2b pulses", pulses, 32'd2);
        chk("b2b first", got[0], 32'd14);
        chk("b2b second", got[1], 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
